acq_sequencer: RTL

Multi-pass acquisition sequencer sitting between the host register file and the acquisition control block, all in the CLK_MASTER domain. On one host GO strobe it waits a head-settle delay, then issues a programmed number of back-to-back acquisition START pulses. For each pass it:
- confirms the acquisition controller armed;
- enforces a trigger-wait timeout using the 500us clock enable;
- counts completed passes.

It terminates cleanly on pass-count reached, RAM full, timeout or host STOP, issuing ABORT to the acquisition controller where required.

---
 rtl/acq_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/acq_sequencer.sv
// Multi-pass acquisition sequencer: settle delay, then N START/arm/run passes with
// arm-guard and trigger-wait timeouts; terminates on count, RAM full, timeout or STOP.
module acq_sequencer #(
    parameter int TIMEOUT_W = 16,
    parameter int ARM_GUARD = 3
) (
    input  logic                 CLK_MASTER,
    input  logic                 RESET,
    input  logic                 CKE_500US,
    input  logic                 GO,
    input  logic                 STOP,
    input  logic [7:0]           PASS_NUM,
    input  logic [7:0]           SETTLE_TICKS,
    input  logic [TIMEOUT_W-1:0] TIMEOUT_TICKS,
    input  logic                 SR_R_FULL,
    input  logic                 ACQ_WAITING,
    input  logic                 ACQ_ACQUIRING,
    output logic                 ACQ_START,
    output logic                 ACQ_ABORT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 TIMED_OUT,
    output logic                 MEM_FULL,
    output logic [7:0]           PASS_COUNT
);

    localparam int GUARD_W = (ARM_GUARD > 1) ? $clog2(ARM_GUARD) : 1;
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(ARM_GUARD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_START, S_ARM, S_RUN, S_ABORT, S_FINISH
    } state_t;

    state_t               r_state;
    logic [7:0]           r_pass_target;
    logic [7:0]           r_settle;
    logic [TIMEOUT_W-1:0] r_timeout;
    logic [7:0]           r_settle_cnt;
    logic [TIMEOUT_W-1:0] r_tick_cnt;
    logic [GUARD_W-1:0]   r_guard_cnt;
    logic [7:0]           r_pass_count;
    logic                 r_timed_out;
    logic                 r_mem_full;

    logic [7:0]           w_settle_next;
    logic                 w_tick_inc;
    logic [TIMEOUT_W-1:0] w_tick_next;
    logic                 w_tick_hit;
    logic                 w_pass_done;
    logic [7:0]           w_count_next;

    // All counters saturate rather than wrap.
    assign w_settle_next = (r_settle_cnt == 8'hFF) ? r_settle_cnt : r_settle_cnt + 8'd1;
    assign w_tick_inc    = ACQ_WAITING && (r_timeout != '0) && CKE_500US;
    assign w_tick_next   = (w_tick_inc && (r_tick_cnt != '1)) ? r_tick_cnt + TIMEOUT_W'(1)
                                                              : r_tick_cnt;
    assign w_tick_hit    = w_tick_inc && (w_tick_next == r_timeout);
    assign w_pass_done   = !ACQ_WAITING && !ACQ_ACQUIRING;
    assign w_count_next  = (r_pass_count == 8'hFF) ? 8'hFF : r_pass_count + 8'd1;

    assign ACQ_START  = (r_state == S_START);
    assign ACQ_ABORT  = (r_state == S_ABORT);
    assign DONE       = (r_state == S_FINISH);
    assign BUSY       = (r_state != S_IDLE);
    assign TIMED_OUT  = r_timed_out;
    assign MEM_FULL   = r_mem_full;
    assign PASS_COUNT = r_pass_count;

    always_ff @(posedge CLK_MASTER or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_pass_target <= '0;
            r_settle      <= '0;
            r_timeout     <= '0;
            r_settle_cnt  <= '0;
            r_tick_cnt    <= '0;
            r_guard_cnt   <= '0;
            r_pass_count  <= '0;
            r_timed_out   <= 1'b0;
            r_mem_full    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (GO && !STOP) begin
                        r_pass_target <= (PASS_NUM == 8'd0) ? 8'd1 : PASS_NUM;
                        r_settle      <= SETTLE_TICKS;
                        r_timeout     <= TIMEOUT_TICKS;
                        r_settle_cnt  <= '0;
                        r_pass_count  <= '0;
                        r_timed_out   <= 1'b0;
                        r_mem_full    <= 1'b0;
                        r_state       <= (SETTLE_TICKS != 8'd0) ? S_SETTLE : S_START;
                    end
                end
                S_SETTLE: begin
                    if (STOP) begin
                        r_state <= S_ABORT;
                    end else if (CKE_500US) begin
                        r_settle_cnt <= w_settle_next;
                        if (w_settle_next == r_settle) begin
                            r_state <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (STOP) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_guard_cnt <= '0;
                        r_tick_cnt  <= '0;
                        r_state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    // Status wins over guard expiry when both land on the same cycle.
                    if (STOP) begin
                        r_state <= S_ABORT;
                    end else if (ACQ_WAITING || ACQ_ACQUIRING) begin
                        r_state <= S_RUN;
                    end else if (r_guard_cnt == GUARD_LAST) begin
                        r_timed_out <= 1'b1;
                        r_state     <= S_ABORT;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + GUARD_W'(1);
                    end
                end
                S_RUN: begin
                    if (STOP) begin
                        r_state <= S_ABORT;
                    end else if (w_pass_done) begin
                        r_pass_count <= w_count_next;
                        if (SR_R_FULL) begin
                            r_mem_full <= 1'b1;
                            r_state    <= S_FINISH;
                        end else if (w_count_next == r_pass_target) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_START;
                        end
                    end else begin
                        r_tick_cnt <= w_tick_next;
                        if (w_tick_hit) begin
                            r_timed_out <= 1'b1;
                            r_state     <= S_ABORT;
                        end
                    end
                end
                S_ABORT:  r_state <= S_FINISH;
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule
